// File: rtl/dispatch_ctrl.sv
// Dispatch credit controller: gates instruction bundles on AL/IQ/branch credits and sequences flush recovery.
// Optional performance counters are built when DISPATCH_CTRL_PERF_EN is defined.
//
// state  | meaning
// RUN    | normal dispatch; credits consumed and released
// FLUSH  | waiting out the recovery latency (down-counter)
// REFILL | one cycle that reloads every credit to its maximum
module dispatch_ctrl #(
    parameter int DISPATCH_WIDTH = 4,
    parameter int AL_SIZE        = 32,
    parameter int IQ_SIZE        = 32,
    parameter int BR_TAGS        = 4,
    parameter int FLUSH_LAT      = 2,
    localparam int AL_W          = $clog2(AL_SIZE + 1),
    localparam int IQ_W          = $clog2(IQ_SIZE + 1),
    localparam int BR_W          = $clog2(BR_TAGS + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            instBufferReady_i,
    input  logic [2:0]      branchCount_i,
    input  logic            backEndStall_i,
    input  logic [2:0]      alRelease_i,
    input  logic [2:0]      iqRelease_i,
    input  logic [2:0]      brRelease_i,
    output logic            stall_o,
    output logic            dispatch_o,
    output logic [AL_W-1:0] alCredit_o,
    output logic [IQ_W-1:0] iqCredit_o,
    output logic [BR_W-1:0] brCredit_o,
    output logic [1:0]      state_o,
    output logic            overflow_o,
    output logic [31:0]     stallCycles_o,
    output logic [31:0]     bundles_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } state_t;

    localparam logic [AL_W:0]   AL_MAX  = (AL_W + 1)'(AL_SIZE);
    localparam logic [IQ_W:0]   IQ_MAX  = (IQ_W + 1)'(IQ_SIZE);
    localparam logic [BR_W:0]   BR_MAX  = (BR_W + 1)'(BR_TAGS);
    localparam logic [AL_W:0]   AL_USE  = (AL_W + 1)'(DISPATCH_WIDTH);
    localparam logic [IQ_W:0]   IQ_USE  = (IQ_W + 1)'(DISPATCH_WIDTH);
    localparam logic [AL_W-1:0] AL_FULL = AL_W'(AL_SIZE);
    localparam logic [IQ_W-1:0] IQ_FULL = IQ_W'(IQ_SIZE);
    localparam logic [BR_W-1:0] BR_FULL = BR_W'(BR_TAGS);
    localparam logic [3:0]      FLUSH_RELOAD = 4'(FLUSH_LAT - 1);

    state_t          state;
    logic [3:0]      flush_cnt;
    logic [AL_W-1:0] al_credit;
    logic [IQ_W-1:0] iq_credit;
    logic [BR_W-1:0] br_credit;
    logic            overflow;

    logic [BR_W:0]   br_need;
    logic            credit_ok;
    logic [AL_W:0]   al_sum;
    logic [IQ_W:0]   iq_sum;
    logic [BR_W:0]   br_sum;
    logic            al_ovf;
    logic            iq_ovf;
    logic            br_ovf;

    assign br_need   = (BR_W + 1)'(branchCount_i);
    assign credit_ok = ({1'b0, al_credit} >= AL_USE) &&
                       ({1'b0, iq_credit} >= IQ_USE) &&
                       ({1'b0, br_credit} >= br_need);

    assign dispatch_o = (state == RUN) && instBufferReady_i && !backEndStall_i &&
                        !flush_i && credit_ok;
    assign stall_o    = !dispatch_o;

    // One guard bit on each sum so a release past the maximum is visible before saturation.
    assign al_sum = {1'b0, al_credit} - (dispatch_o ? AL_USE : '0) + (AL_W + 1)'(alRelease_i);
    assign iq_sum = {1'b0, iq_credit} - (dispatch_o ? IQ_USE : '0) + (IQ_W + 1)'(iqRelease_i);
    assign br_sum = {1'b0, br_credit} - (dispatch_o ? br_need : '0) + (BR_W + 1)'(brRelease_i);
    assign al_ovf = al_sum > AL_MAX;
    assign iq_ovf = iq_sum > IQ_MAX;
    assign br_ovf = br_sum > BR_MAX;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            al_credit <= AL_FULL;
            iq_credit <= IQ_FULL;
            br_credit <= BR_FULL;
            overflow  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    al_credit <= al_ovf ? AL_FULL : al_sum[AL_W-1:0];
                    iq_credit <= iq_ovf ? IQ_FULL : iq_sum[IQ_W-1:0];
                    br_credit <= br_ovf ? BR_FULL : br_sum[BR_W-1:0];
                    overflow  <= overflow | al_ovf | iq_ovf | br_ovf;
                    if (flush_i) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_RELOAD;
                    end
                end
                FLUSH: begin
                    if (flush_i) begin
                        flush_cnt <= FLUSH_RELOAD;
                    end else if (flush_cnt == '0) begin
                        state <= REFILL;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                REFILL: begin
                    // A new flush wins over the reload; the reload happens on the next REFILL.
                    if (flush_i) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_RELOAD;
                    end else begin
                        al_credit <= AL_FULL;
                        iq_credit <= IQ_FULL;
                        br_credit <= BR_FULL;
                        state     <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign state_o    = state;
    assign alCredit_o = al_credit;
    assign iqCredit_o = iq_credit;
    assign brCredit_o = br_credit;
    assign overflow_o = overflow;

`ifdef DISPATCH_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bundle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bundle_cnt <= '0;
        end else begin
            if (instBufferReady_i && !dispatch_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (dispatch_o && (bundle_cnt != '1)) begin
                bundle_cnt <= bundle_cnt + 32'd1;
            end
        end
    end

    assign stallCycles_o = stall_cnt;
    assign bundles_o     = bundle_cnt;
`else
    assign stallCycles_o = '0;
    assign bundles_o     = '0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus randomized traffic
// compared against a cycles-since-flush reference model.
module tb_dispatch_ctrl;

    localparam int DW  = 4;
    localparam int ALS = 32;
    localparam int IQS = 32;
    localparam int BRT = 4;
    localparam int FL  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush_i = 1'b0;
    logic        instBufferReady_i = 1'b0;
    logic [2:0]  branchCount_i = '0;
    logic        backEndStall_i = 1'b0;
    logic [2:0]  alRelease_i = '0;
    logic [2:0]  iqRelease_i = '0;
    logic [2:0]  brRelease_i = '0;
    logic        stall_o;
    logic        dispatch_o;
    logic [5:0]  alCredit_o;
    logic [5:0]  iqCredit_o;
    logic [2:0]  brCredit_o;
    logic [1:0]  state_o;
    logic        overflow_o;
    logic [31:0] stallCycles_o;
    logic [31:0] bundles_o;

    int checks = 0;
    int errors = 0;

    int m_al, m_iq, m_br, m_since, m_stall, m_bund;
    bit m_ovf;

    dispatch_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .flush_i           (flush_i),
        .instBufferReady_i (instBufferReady_i),
        .branchCount_i     (branchCount_i),
        .backEndStall_i    (backEndStall_i),
        .alRelease_i       (alRelease_i),
        .iqRelease_i       (iqRelease_i),
        .brRelease_i       (brRelease_i),
        .stall_o           (stall_o),
        .dispatch_o        (dispatch_o),
        .alCredit_o        (alCredit_o),
        .iqCredit_o        (iqCredit_o),
        .brCredit_o        (brCredit_o),
        .state_o           (state_o),
        .overflow_o        (overflow_o),
        .stallCycles_o     (stallCycles_o),
        .bundles_o         (bundles_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // m_since counts cycles since the flush was sampled; FL+2 means settled in RUN.
    function automatic int m_state();
        if (m_since >= 1 && m_since <= FL) return 1;
        if (m_since == FL + 1) return 2;
        return 0;
    endfunction

    function automatic bit m_disp();
        return (m_state() == 0) && instBufferReady_i && !backEndStall_i && !flush_i &&
               (m_al >= DW) && (m_iq >= DW) && (m_br >= int'(branchCount_i));
    endfunction

    task automatic model_reset();
        m_al = ALS; m_iq = IQS; m_br = BRT;
        m_since = FL + 2; m_ovf = 1'b0; m_stall = 0; m_bund = 0;
    endtask

    task automatic check_all();
        bit d = m_disp();
        chk("state", 32'(state_o), 32'(m_state()));
        chk("dispatch", 32'(dispatch_o), 32'(d));
        chk("stall", 32'(stall_o), 32'(!d));
        chk("al_credit", 32'(alCredit_o), 32'(m_al));
        chk("iq_credit", 32'(iqCredit_o), 32'(m_iq));
        chk("br_credit", 32'(brCredit_o), 32'(m_br));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
`ifdef DISPATCH_CTRL_PERF_EN
        chk("stall_cycles", stallCycles_o, 32'(m_stall));
        chk("bundles", bundles_o, 32'(m_bund));
`else
        chk("stall_cycles", stallCycles_o, 32'd0);
        chk("bundles", bundles_o, 32'd0);
`endif
    endtask

    task automatic model_edge();
        bit d = m_disp();
        int st = m_state();
        if (instBufferReady_i && !d) m_stall++;
        if (d) m_bund++;
        if (st == 0) begin
            m_al = m_al - (d ? DW : 0) + int'(alRelease_i);
            m_iq = m_iq - (d ? DW : 0) + int'(iqRelease_i);
            m_br = m_br - (d ? int'(branchCount_i) : 0) + int'(brRelease_i);
            if (m_al > ALS) begin m_al = ALS; m_ovf = 1'b1; end
            if (m_iq > IQS) begin m_iq = IQS; m_ovf = 1'b1; end
            if (m_br > BRT) begin m_br = BRT; m_ovf = 1'b1; end
        end
        if (flush_i) begin
            m_since = 1;
        end else if (m_since <= FL + 1) begin
            m_since++;
            if (m_since == FL + 2) begin
                m_al = ALS; m_iq = IQS; m_br = BRT;
            end
        end
    endtask

    task automatic step(input bit f, input bit r, input int bc, input bit s,
                        input int alr, input int iqr, input int brr);
        @(negedge clk);
        flush_i           = f;
        instBufferReady_i = r;
        branchCount_i     = 3'(bc);
        backEndStall_i    = s;
        alRelease_i       = 3'(alr);
        iqRelease_i       = 3'(iqr);
        brRelease_i       = 3'(brr);
        #1;
        check_all();
        model_edge();
    endtask

    // Reset is asserted mid-cycle so its asynchronous effect is checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        flush_i = 1'b0; instBufferReady_i = 1'b0; branchCount_i = '0; backEndStall_i = 1'b0;
        alRelease_i = '0; iqRelease_i = '0; brRelease_i = '0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Branch tags run out after four single-branch bundles, then AL/IQ after four more.
        repeat (5) step(0, 1, 1, 0, 0, 0, 0);
        chk("br_exhausted", 32'(brCredit_o), 32'd0);
        chk("br_block", 32'(stall_o), 32'd1);
        repeat (5) step(0, 1, 0, 0, 0, 0, 0);
        chk("al_exhausted", 32'(alCredit_o), 32'd0);
        chk("iq_exhausted", 32'(iqCredit_o), 32'd0);

        // Consume and release in the same cycle at the AL threshold.
        do_reset();
        repeat (7) step(0, 1, 0, 0, 0, 4, 0);
        step(0, 1, 0, 0, 4, 4, 0);
        chk("al_boundary_disp", 32'(dispatch_o), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("al_hold", 32'(alCredit_o), 32'd4);
        chk("iq_hold", 32'(iqCredit_o), 32'd32);

        // Release on a full credit saturates and latches overflow.
        do_reset();
        step(0, 0, 0, 0, 3, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        chk("al_saturated", 32'(alCredit_o), 32'd32);

        // Flush timing: REFILL at t+3, dispatch at t+4.
        do_reset();
        repeat (3) step(0, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 2, 2, 2);
        repeat (3) step(0, 1, 1, 0, 3, 3, 3);
        chk("refill_state", 32'(state_o), 32'd2);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("first_disp", 32'(dispatch_o), 32'd1);

        // Re-flush two cycles in pushes REFILL out to t+5.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0, 0);
        chk("reflush_refill", 32'(state_o), 32'd2);
        step(0, 1, 0, 0, 0, 0, 0);

        // Reset in the middle of FLUSH.
        step(0, 0, 0, 0, 4, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);

        // Performance counters: three ready-but-stalled cycles, then two bundles.
        do_reset();
        repeat (3) step(0, 1, 0, 1, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
`ifdef DISPATCH_CTRL_PERF_EN
        chk("perf_stalls", stallCycles_o, 32'd3);
        chk("perf_bundles", bundles_o, 32'd2);
`else
        chk("perf_stalls", stallCycles_o, 32'd0);
        chk("perf_bundles", bundles_o, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 24) == 0,
                     $urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 4)),
                     $urandom_range(0, 4) == 0,
                     ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4)) : 0,
                     ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4)) : 0,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
